instr_sequencer: RTL and testbench

- Instruction fetch/issue stage directly upstream of the CU decoder.
- Walks a synchronous instruction ROM from address 0 and presents each instruction's 4-bit opcode and operand field to the CU over a valid/ready handshake.
- Executes the two control opcodes itself, so they never reach the CU: LOOP (4'b1110), a single-level counted back-jump, and HALT (4'b1111).

---
 rtl/instr_sequencer.sv | 162 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction fetch/issue stage: walks a synchronous ROM from address 0 and hands
// opcode/operand to the CU over valid/ready, executing LOOP and HALT locally.
module instr_sequencer #(
   parameter int OP_WIDTH   = 4,
   parameter int ARG_WIDTH  = 12,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   output logic [ADDR_WIDTH-1:0]         imem_addr,
   input  logic [OP_WIDTH+ARG_WIDTH-1:0] imem_rdata,
   output logic [OP_WIDTH-1:0]           opcode,
   output logic [ARG_WIDTH-1:0]          operand,
   output logic                          instr_valid,
   input  logic                          instr_ready,
   output logic [ADDR_WIDTH-1:0]         pc,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int IW = OP_WIDTH + ARG_WIDTH;
   localparam logic [OP_WIDTH-1:0]   OP_HALT  = {OP_WIDTH{1'b1}};
   localparam logic [OP_WIDTH-1:0]   OP_LOOP  = {{(OP_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [ADDR_WIDTH-1:0] PC_ZERO  = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] PC_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PC_LAST  = {ADDR_WIDTH{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_EXEC  = 3'd3,
      S_ISSUE = 3'd4
   } state_t;

   state_t                  state_r;
   logic [ADDR_WIDTH-1:0]   pc_r;
   logic [IW-1:0]           instr_r;
   logic [OP_WIDTH-1:0]     opcode_r;
   logic [ARG_WIDTH-1:0]    operand_r;
   logic                    valid_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    err_r;
   logic [3:0]              loop_cnt_r;
   logic                    loop_active_r;

   logic [OP_WIDTH-1:0]     instr_op_s;
   logic [ARG_WIDTH-1:0]    instr_arg_s;
   logic [3:0]              loop_n_s;
   logic [ADDR_WIDTH-1:0]   loop_tgt_s;
   logic                    pc_last_s;
   logic                    loop_jump_s;

   assign instr_op_s  = instr_r[IW-1 -: OP_WIDTH];
   assign instr_arg_s = instr_r[ARG_WIDTH-1:0];
   assign loop_n_s    = instr_arg_s[3:0];
   assign loop_tgt_s  = instr_arg_s[4 +: ADDR_WIDTH];
   assign pc_last_s   = (pc_r == PC_LAST);
   // A LOOP jumps back while the shared counter still has passes left.
   assign loop_jump_s = loop_active_r ? (loop_cnt_r != 4'd0) : (loop_n_s != 4'd0);

   assign imem_addr   = pc_r;
   assign pc          = pc_r;
   assign opcode      = opcode_r;
   assign operand     = operand_r;
   assign instr_valid = valid_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign err         = err_r;

   // Sequencer FSM: fetch, wait for ROM data, classify, and issue or execute locally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= S_IDLE;
         pc_r          <= PC_ZERO;
         instr_r       <= {IW{1'b0}};
         opcode_r      <= {OP_WIDTH{1'b0}};
         operand_r     <= {ARG_WIDTH{1'b0}};
         valid_r       <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         err_r         <= 1'b0;
         loop_cnt_r    <= 4'd0;
         loop_active_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  pc_r          <= PC_ZERO;
                  busy_r        <= 1'b1;
                  err_r         <= 1'b0;
                  loop_cnt_r    <= 4'd0;
                  loop_active_r <= 1'b0;
                  state_r       <= S_FETCH;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_FETCH: state_r <= S_WAIT;
            S_WAIT: begin
               instr_r <= imem_rdata;
               state_r <= S_EXEC;
            end
            S_EXEC: begin
               if (instr_op_s == OP_HALT) begin
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end else if (instr_op_s == OP_LOOP) begin
                  if (loop_jump_s) begin
                     loop_cnt_r    <= loop_active_r ? (loop_cnt_r - 4'd1) : (loop_n_s - 4'd1);
                     loop_active_r <= 1'b1;
                     pc_r          <= loop_tgt_s;
                     state_r       <= S_FETCH;
                  end else if (pc_last_s) begin
                     loop_active_r <= 1'b0;
                     err_r         <= 1'b1;
                     done_r        <= 1'b1;
                     busy_r        <= 1'b0;
                     state_r       <= S_IDLE;
                  end else begin
                     loop_active_r <= 1'b0;
                     pc_r          <= pc_r + PC_ONE;
                     state_r       <= S_FETCH;
                  end
               end else begin
                  opcode_r  <= instr_op_s;
                  operand_r <= instr_arg_s;
                  valid_r   <= 1'b1;
                  state_r   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (valid_r && instr_ready) begin
                  valid_r <= 1'b0;
                  if (pc_last_s) begin
                     err_r   <= 1'b1;
                     done_r  <= 1'b1;
                     busy_r  <= 1'b0;
                     state_r <= S_IDLE;
                  end else begin
                     pc_r    <= pc_r + PC_ONE;
                     state_r <= S_FETCH;
                  end
               end else begin
                  state_r <= S_ISSUE;
               end
            end
            default: begin
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: table-driven programs, hand-written corner sequences,
// and random programs checked against an interpreter-style reference model.
module tb_instr_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic [3:0]  opcode;
   logic [11:0] operand;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  pc;
   logic        busy;
   logic        done;
   logic        err;

   logic        s_start;
   logic [1:0]  s_addr;
   logic [15:0] s_rdata;
   logic [3:0]  s_opcode;
   logic [11:0] s_operand;
   logic        s_valid;
   logic        s_ready;
   logic [1:0]  s_pc;
   logic        s_busy;
   logic        s_done;
   logic        s_err;

   logic [15:0] rom  [256];
   logic [15:0] srom [4];

   int checks;
   int errors;
   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];
   bit   exp_err;
   int   done_cnt;
   logic fin_err;
   int   first_valid_cyc;

   instr_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .opcode(opcode), .operand(operand),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
      .busy(busy), .done(done), .err(err)
   );

   instr_sequencer #(.ADDR_WIDTH(2)) dut_small (
      .clk(clk), .rst_n(rst_n), .start(s_start), .imem_addr(s_addr),
      .imem_rdata(s_rdata), .opcode(s_opcode), .operand(s_operand),
      .instr_valid(s_valid), .instr_ready(s_ready), .pc(s_pc),
      .busy(s_busy), .done(s_done), .err(s_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      imem_rdata <= rom[imem_addr];
      s_rdata    <= srom[s_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [0:7][15:0] prog;
      int               n;
      logic [0:7][15:0] seq;
      logic             e;
   } vec_t;
   vec_t vecs[7];

   task automatic load_prog(input logic [0:7][15:0] p);
      for (int a = 0; a < 256; a++) rom[a] = 16'hF000;
      for (int k = 0; k < 8; k++) rom[k] = p[k];
   endtask

   // Reference: interpret the ROM as a program, listing the words the CU must receive.
   task automatic build_expected();
      int pc_m, cnt, steps;
      bit act;
      logic [15:0] w;
      exp_q.delete();
      exp_err = 1'b0;
      pc_m = 0; cnt = 0; act = 1'b0;
      for (steps = 0; steps < 5000; steps++) begin
         w = rom[pc_m];
         if (w[15:12] == 4'hF) break;
         if (w[15:12] == 4'hE) begin
            if (!act && w[3:0] != 4'd0) begin
               act = 1'b1; cnt = int'(w[3:0]) - 1; pc_m = int'(w[11:4]); continue;
            end
            if (act && cnt != 0) begin
               cnt = cnt - 1; pc_m = int'(w[11:4]); continue;
            end
            act = 1'b0;
         end else begin
            exp_q.push_back(w);
         end
         if (pc_m == 255) begin
            exp_err = 1'b1;
            break;
         end
         pc_m = pc_m + 1;
      end
   endtask

   // Runs one program on the main DUT; mode 0 ready high, 1 random, 2 stall first issue 5 cycles.
   task automatic run_main(input int mode);
      bit          fin;
      bit          stall_prev;
      logic [15:0] held;
      logic [7:0]  held_pc;
      int          stall_left;
      got_q.delete();
      done_cnt = 0;
      fin_err = 1'b0;
      first_valid_cyc = -1;
      stall_prev = 1'b0;
      held = 16'h0000;
      held_pc = 8'h00;
      stall_left = (mode == 2) ? 5 : 0;
      fin = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
         if (stall_prev) begin
            chk("stall_valid", instr_valid, 1);
            chk("stall_word", {opcode, operand}, held);
            chk("stall_pc", pc, held_pc);
         end
         if (done) begin
            done_cnt++;
            fin_err = err;
            chk("busy_at_done", busy, 0);
            fin = 1'b1;
         end else begin
            if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            case (mode)
               0:       instr_ready = 1'b1;
               1:       instr_ready = ($urandom_range(0, 1) == 1);
               default: begin
                  instr_ready = !(instr_valid && stall_left > 0);
                  if (instr_valid && stall_left > 0) stall_left--;
               end
            endcase
            if (instr_valid && instr_ready) got_q.push_back({opcode, operand});
            stall_prev = instr_valid && !instr_ready;
            held = {opcode, operand};
            held_pc = pc;
            @(negedge clk);
         end
      end
      if (!fin) begin
         errors++;
         $display("FAIL run_timeout: got no done expected done within budget");
      end
      @(negedge clk);
      chk("done_single_pulse", done, 0);
   endtask

   task automatic compare_run(input string nm);
      chk({nm, "_count"}, got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
         chk({nm, "_word"}, got_q[k], exp_q[k]);
      chk({nm, "_err"}, fin_err, exp_err);
      chk({nm, "_done_cnt"}, done_cnt, 1);
   endtask

   initial begin
      int issues;
      int len;
      int lp;
      bit sfin;
      checks = 0; errors = 0;
      rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
      s_start = 1'b0; s_ready = 1'b1;
      for (int a = 0; a < 4; a++) srom[a] = 16'h0000;
      for (int a = 0; a < 256; a++) rom[a] = 16'hF000;

      vecs[0] = '{prog: {16'h0005, 16'h1003, 16'h2007, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000},
                  n: 3, seq: {16'h0005, 16'h1003, 16'h2007, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, e: 1'b0};
      vecs[1] = '{prog: {16'h3001, 16'hE003, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000},
                  n: 4, seq: {16'h3001, 16'h3001, 16'h3001, 16'h3001, 16'h0, 16'h0, 16'h0, 16'h0}, e: 1'b0};
      vecs[2] = '{prog: {16'h3001, 16'hE000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000},
                  n: 1, seq: {16'h3001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, e: 1'b0};
      vecs[3] = '{prog: {16'hF000, 16'h1111, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000},
                  n: 0, seq: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, e: 1'b0};
      vecs[4] = '{prog: {16'hE002, 16'h4444, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000},
                  n: 1, seq: {16'h4444, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, e: 1'b0};
      vecs[5] = '{prog: {16'h1111, 16'hE012, 16'h2222, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000},
                  n: 2, seq: {16'h1111, 16'h2222, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, e: 1'b0};
      vecs[6] = '{prog: {16'h5005, 16'h6006, 16'hE002, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000},
                  n: 6, seq: {16'h5005, 16'h6006, 16'h5005, 16'h6006, 16'h5005, 16'h6006, 16'h0, 16'h0}, e: 1'b0};

      #12;
      chk("rst_valid", instr_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_pc", pc, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_word", {opcode, operand}, 0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         load_prog(vecs[i].prog);
         run_main(0);
         chk("vec_count", got_q.size(), vecs[i].n);
         for (int k = 0; k < vecs[i].n && k < got_q.size(); k++)
            chk("vec_word", got_q[k], vecs[i].seq[k]);
         chk("vec_err", fin_err, vecs[i].e);
         chk("vec_done_cnt", done_cnt, 1);
         if (i == 0) chk("first_valid_latency", first_valid_cyc, 3);
      end

      // First issue stalled for five cycles.
      load_prog(vecs[0].prog);
      run_main(2);
      chk("stall_count", got_q.size(), 3);
      chk("stall_first", got_q.size() > 0 ? got_q[0] : 16'hDEAD, 16'h0005);
      chk("stall_err", fin_err, 0);

      // Overrun on the 4-entry instance: no HALT anywhere.
      for (int pass = 0; pass < 2; pass++) begin
         @(negedge clk); s_start = 1'b1;
         @(negedge clk); s_start = 1'b0;
         if (pass == 1) chk("small_err_cleared", s_err, 0);
         issues = 0; sfin = 1'b0;
         for (int cyc = 0; cyc < 200 && !sfin; cyc++) begin
            if (s_done) sfin = 1'b1;
            else begin
               if (s_valid && s_ready) issues++;
               @(negedge clk);
            end
         end
         chk("small_finished", sfin, 1);
         chk("small_issues", issues, 4);
         chk("small_err", s_err, 1);
         chk("small_busy", s_busy, 0);
      end

      // Asynchronous reset while an instruction is waiting in ISSUE.
      load_prog(vecs[0].prog);
      instr_ready = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 20 && !instr_valid; k++) @(negedge clk);
      chk("pre_rst_valid", instr_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", instr_valid, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_pc", pc, 0);
      @(negedge clk); rst_n = 1'b1;
      build_expected();
      run_main(0);
      compare_run("after_rst");

      // Random programs, at most one LOOP each, with random ready.
      for (int t = 0; t < 20; t++) begin
         for (int a = 0; a < 256; a++) rom[a] = 16'hF000;
         len = $urandom_range(2, 12);
         for (int a = 0; a < len; a++)
            rom[a] = {4'($urandom_range(0, 13)), 12'($urandom)};
         if ($urandom_range(0, 3) != 0) begin
            lp = $urandom_range(1, len - 1);
            rom[lp] = {4'hE, 8'($urandom_range(0, lp)), 4'($urandom_range(0, 5))};
         end
         build_expected();
         run_main(1);
         compare_run("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
